// File: rtl/sys_bus_pkg.sv
// Shared types and widths for sys_bus slave endpoints.
package sys_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  localparam int BUS_DW = 32;
  localparam int OVR_W  = 16;
endpackage

// File: rtl/sys_bus_reg_responder.sv
// sys_bus slave register bank: NR 32-bit registers with read-only status words,
// shadowed registers committed on commit_i, and RL programmable wait states.
module sys_bus_reg_responder
  import sys_bus_pkg::*;
#(
  parameter int          SW      = 20,
  parameter int          NR      = 16,
  parameter int          RL      = 0,
  parameter logic [NR-1:0] RO_MASK = '0,
  parameter logic [NR-1:0] SH_MASK = '0,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [SW-1:0]        sys_addr,
  input  logic [BUS_DW-1:0]    sys_wdata,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [BUS_DW-1:0]    sys_rdata,
  output logic                 sys_err,
  output logic                 sys_ack,
  input  logic                 commit_i,
  input  logic [NR*BUS_DW-1:0] sts_i,
  output logic [NR*BUS_DW-1:0] cfg_o,
  output logic [NR-1:0]        upd_o,
  output logic [OVR_W-1:0]     ovr_cnt_o
);
  localparam int         IW    = SW - 2;
  localparam logic [3:0] RL_M1 = (RL > 0) ? 4'(RL - 1) : 4'd0;

  resp_state_t                state;
  logic [3:0]                 wcnt;
  logic                       resp_err;
  logic [NR-1:0][BUS_DW-1:0]  act_all;
  logic [NR-1:0][BUS_DW-1:0]  sts;
  logic [IW-1:0]              idx;
  logic [NR-1:0]              hit;
  logic [BUS_DW-1:0]          rd_word;
  logic                       strobe, accept, bad, wr_ok;

  assign sts   = sts_i;
  assign cfg_o = act_all;
  assign idx   = sys_addr[SW-1:2];

  // One-hot decode; an index at or beyond NR hits nothing, which flags it out of range.
  for (genvar k = 0; k < NR; k++) begin : g_hit
    assign hit[k] = (idx == IW'(k));
  end

  assign strobe = sys_wen | sys_ren;
  assign accept = strobe && (state == IDLE);
  assign bad    = !(|hit) || (sys_addr[1:0] != 2'b00) || (sys_wen && |(hit & RO_MASK));
  assign wr_ok  = accept && sys_wen && !bad;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NR; k++)
      if (hit[k]) rd_word = RO_MASK[k] ? sts[k] : act_all[k];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      wcnt      <= '0;
      resp_err  <= 1'b0;
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
      ovr_cnt_o <= '0;
    end else begin
      sys_ack <= 1'b0;
      sys_err <= 1'b0;
      if (strobe && state != IDLE && ovr_cnt_o != '1)
        ovr_cnt_o <= ovr_cnt_o + 1'b1;
      case (state)
        IDLE: if (strobe) begin
          resp_err  <= bad;
          sys_rdata <= (sys_wen || bad) ? '0 : rd_word;
          if (RL == 0) begin
            state   <= RESP;
            sys_ack <= !bad;
            sys_err <= bad;
          end else begin
            state <= WAIT;
            wcnt  <= RL_M1;
          end
        end
        WAIT: if (wcnt == '0) begin
          state   <= RESP;
          sys_ack <= !resp_err;
          sys_err <= resp_err;
        end else begin
          wcnt <= wcnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_reg
    logic [BUS_DW-1:0] act_q;
    logic              upd_q;
    assign act_all[k] = act_q;
    assign upd_o[k]   = upd_q;

    if (SH_MASK[k]) begin : g_sh
      logic [BUS_DW-1:0] sh_q;
      // Commit copies the pre-edge shadow, so a coincident write lands one commit later.
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          act_q <= RST_VAL;
          sh_q  <= RST_VAL;
          upd_q <= 1'b0;
        end else begin
          upd_q <= 1'b0;
          if (wr_ok && hit[k]) sh_q <= sys_wdata;
          if (commit_i) begin
            act_q <= sh_q;
            upd_q <= (sh_q != act_q);
          end
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          act_q <= RST_VAL;
          upd_q <= 1'b0;
        end else begin
          upd_q <= wr_ok && hit[k];
          if (wr_ok && hit[k]) act_q <= sys_wdata;
        end
      end
    end
  end
endmodule
